// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin sensors/vending logic and coin_acceptor.
// The slave side is the acceptor. state_dbg exposes the acceptor FSM state for observation.
interface coin_acceptor_if;
  logic       dime_raw;
  logic       quarter_raw;
  logic       enable;
  logic       D;
  logic       Q;
  logic       reject;
  logic       jam;
  logic [7:0] coin_count;
  logic [2:0] state_dbg;

  modport master (
    output dime_raw, quarter_raw, enable,
    input  D, Q, reject, jam, coin_count, state_dbg
  );

  modport slave (
    input  dime_raw, quarter_raw, enable,
    output D, Q, reject, jam, coin_count, state_dbg
  );
endinterface

// File: rtl/coin_acceptor.sv
// Debounced dime/quarter acceptor: one D/Q/reject pulse per coin, jam detection on
// over-long holds, and a saturating count of accepted coins.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  coin_acceptor_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    RELEASE_DB = 3'd3,
    JAM        = 3'd4
  } state_t;

  // The sample that moves us out of IDLE/HELD already counts as the first of N,
  // hence the N-2 reload; entering JAM has not yet seen a low sample, hence N-1.
  localparam logic [7:0]  DB_FIRST = 8'(DEBOUNCE_CYCLES - 2);
  localparam logic [7:0]  DB_FULL  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] JAM_LIM  = 16'(JAM_CYCLES);

  state_t      state, state_nx;
  logic [1:0]  sync_d, sync_q;
  logic [7:0]  db_cnt, db_cnt_nx;
  logic [15:0] hold_cnt, hold_cnt_nx;
  logic        coin_type, coin_type_nx;   // 1 = quarter
  logic        d_r, q_r, rej_r;
  logic        d_nx, q_nx, rej_nx;
  logic [7:0]  count_r;

  logic sd, sq, both, none, one, own;
  assign sd   = sync_d[1];
  assign sq   = sync_q[1];
  assign both = sd & sq;
  assign none = ~sd & ~sq;
  assign one  = sd ^ sq;
  assign own  = coin_type ? (sq & ~sd) : (sd & ~sq);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_d    <= 2'b00;
      sync_q    <= 2'b00;
      state     <= IDLE;
      db_cnt    <= 8'd0;
      hold_cnt  <= 16'd0;
      coin_type <= 1'b0;
      d_r       <= 1'b0;
      q_r       <= 1'b0;
      rej_r     <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      sync_d    <= {sync_d[0], bus.dime_raw};
      sync_q    <= {sync_q[0], bus.quarter_raw};
      state     <= state_nx;
      db_cnt    <= db_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      coin_type <= coin_type_nx;
      d_r       <= d_nx;
      q_r       <= q_nx;
      rej_r     <= rej_nx;
      if ((d_nx || q_nx) && count_r != 8'hFF)
        count_r <= count_r + 8'd1;
    end
  end

  always_comb begin
    state_nx     = state;
    db_cnt_nx    = db_cnt;
    hold_cnt_nx  = hold_cnt;
    coin_type_nx = coin_type;
    d_nx         = 1'b0;
    q_nx         = 1'b0;
    rej_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (both) begin
          rej_nx      = 1'b1;
          hold_cnt_nx = 16'd1;
          state_nx    = HELD;
        end else if (one) begin
          coin_type_nx = sq;
          db_cnt_nx    = DB_FIRST;
          state_nx     = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (both) begin
          rej_nx      = 1'b1;
          hold_cnt_nx = 16'd1;
          state_nx    = HELD;
        end else if (own) begin
          if (db_cnt == 8'd0) begin
            // enable matters only on this accept cycle
            d_nx        = bus.enable & ~coin_type;
            q_nx        = bus.enable &  coin_type;
            rej_nx      = ~bus.enable;
            hold_cnt_nx = 16'd1;
            state_nx    = HELD;
          end else begin
            db_cnt_nx = db_cnt - 8'd1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      HELD: begin
        if (hold_cnt != 16'hFFFF) hold_cnt_nx = hold_cnt + 16'd1;
        if (none) begin
          db_cnt_nx = DB_FIRST;
          state_nx  = RELEASE_DB;
        end else if (hold_cnt >= JAM_LIM) begin
          db_cnt_nx = DB_FULL;
          state_nx  = JAM;
        end
      end
      RELEASE_DB: begin
        if (hold_cnt != 16'hFFFF) hold_cnt_nx = hold_cnt + 16'd1;
        if (!none)                state_nx  = HELD;
        else if (db_cnt == 8'd0)  state_nx  = IDLE;
        else                      db_cnt_nx = db_cnt - 8'd1;
      end
      JAM: begin
        if (!none)                db_cnt_nx = DB_FULL;
        else if (db_cnt == 8'd0)  state_nx  = IDLE;
        else                      db_cnt_nx = db_cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.D          = d_r;
  assign bus.Q          = q_r;
  assign bus.reject     = rej_r;
  assign bus.jam        = (state == JAM);
  assign bus.coin_count = count_r;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a run-length model of the coin rules feeds an
// expected queue checked every cycle, plus hand-computed checkpoints.
module tb_coin_acceptor;
  localparam int DB  = 4;
  localparam int JAM = 64;
  localparam int W   = 12;

  logic clock;
  logic reset_n;
  coin_acceptor_if bus();

  coin_acceptor #(.DEBOUNCE_CYCLES(DB), .JAM_CYCLES(JAM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int d_seen = 0, q_seen = 0, rej_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Coins are tracked by run lengths of synchronized samples: a candidate run of N
  // matching samples accepts, N all-low samples frees the slot, a hold of JAM cycles jams.
  logic [W-1:0] exp_q[$];
  logic p1_d, p2_d, p1_q, p2_q;
  int   cand, run, low_run, age, m_count;
  bit   occupied, jammed, was_held;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_d = 0; p2_d = 0; p1_q = 0; p2_q = 0;
      cand = 0; run = 0; low_run = 0; age = 0; m_count = 0;
      occupied = 0; jammed = 0;
      exp_q.delete();
    end else begin
      logic sd, sq, any_high, e_d, e_q, e_rej;
      sd = p2_d; sq = p2_q;
      p2_d = p1_d; p2_q = p1_q;
      p1_d = bus.dime_raw; p1_q = bus.quarter_raw;
      e_d = 0; e_q = 0; e_rej = 0;
      any_high = sd || sq;
      if (jammed) begin
        low_run = any_high ? 0 : low_run + 1;
        if (low_run == DB) jammed = 0;
      end else if (occupied) begin
        was_held = (low_run == 0);
        if (age < 65535) age++;
        low_run = any_high ? 0 : low_run + 1;
        if (low_run == DB) occupied = 0;
        else if (was_held && any_high && age >= JAM) begin
          occupied = 0; jammed = 1; low_run = 0;
        end
      end else if (sd && sq) begin
        e_rej = 1; occupied = 1; age = 0; low_run = 0; cand = 0;
      end else if (cand != 0 && ((cand == 1 && sd) || (cand == 2 && sq))) begin
        run++;
        if (run == DB) begin
          e_d   = bus.enable && cand == 1;
          e_q   = bus.enable && cand == 2;
          e_rej = !bus.enable;
          occupied = 1; age = 0; low_run = 0; cand = 0;
        end
      end else if (cand != 0) begin
        cand = 0;
      end else if (sd != sq) begin
        cand = sd ? 1 : 2; run = 1;
      end
      if ((e_d || e_q) && m_count < 255) m_count++;
      exp_q.push_back({e_d, e_q, e_rej, jammed, 8'(m_count)});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (reset_n && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("D",          int'(bus.D),          int'(e[11]));
      check("Q",          int'(bus.Q),          int'(e[10]));
      check("reject",     int'(bus.reject),     int'(e[9]));
      check("jam",        int'(bus.jam),        int'(e[8]));
      check("coin_count", int'(bus.coin_count), int'(e[7:0]));
      check("one_pulse",  int'(bus.D) + int'(bus.Q) + int'(bus.reject) <= 1 ? 1 : 0, 1);
      if (bus.D) d_seen++;
      if (bus.Q) q_seen++;
      if (bus.reject) rej_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic d, input logic q, input logic en, input int n);
    for (int i = 0; i < n; i++) begin
      bus.dime_raw    = d;
      bus.quarter_raw = q;
      bus.enable      = en;
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    bus.dime_raw = 0; bus.quarter_raw = 0; bus.enable = 1;
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int bd, bq, br;
    bus.dime_raw = 0; bus.quarter_raw = 0; bus.enable = 1;
    reset_n = 0;
    repeat (2) @(negedge clock);
    check("rst_D", int'(bus.D), 0);
    check("rst_Q", int'(bus.Q), 0);
    check("rst_reject", int'(bus.reject), 0);
    check("rst_jam", int'(bus.jam), 0);
    check("rst_count", int'(bus.coin_count), 0);
    reset_n = 1;
    @(negedge clock);

    // quarter held 20 cycles: Q exactly after the 6th edge
    bd = d_seen; bq = q_seen; br = rej_seen;
    step(0, 1, 1, 5);  check("q_edge5", int'(bus.Q), 0);
    step(0, 1, 1, 1);  check("q_edge6", int'(bus.Q), 1);
    step(0, 1, 1, 1);  check("q_edge7", int'(bus.Q), 0);
    step(0, 1, 1, 13);
    step(0, 0, 1, 8);
    check("q20_count", int'(bus.coin_count), 1);
    check("q20_qpulses", q_seen - bq, 1);
    check("q20_dpulses", d_seen - bd, 0);
    check("q20_rejects", rej_seen - br, 0);

    // three glitches then a clean press
    do_reset(); bd = d_seen;
    for (int g = 0; g < 3; g++) begin step(1, 0, 1, 1); step(0, 0, 1, 2); end
    step(1, 0, 1, 10); step(0, 0, 1, 8);
    check("glitch_dpulses", d_seen - bd, 1);
    check("glitch_count", int'(bus.coin_count), 1);

    // short gap of 3 low cycles: same coin
    do_reset(); bd = d_seen;
    step(1, 0, 1, 8); step(0, 0, 1, 3); step(1, 0, 1, 8); step(0, 0, 1, 8);
    check("gap3_dpulses", d_seen - bd, 1);

    // gap of 6 low cycles: two coins
    do_reset(); bd = d_seen;
    step(1, 0, 1, 8); step(0, 0, 1, 6); step(1, 0, 1, 8); step(0, 0, 1, 8);
    check("gap6_dpulses", d_seen - bd, 2);
    check("gap6_count", int'(bus.coin_count), 2);

    // both sensors together, then dime with enable low, then enable raised mid-debounce
    do_reset(); bd = d_seen; bq = q_seen; br = rej_seen;
    step(1, 1, 1, 8); step(0, 0, 1, 8);
    check("both_rejects", rej_seen - br, 1);
    check("both_count", int'(bus.coin_count), 0);
    step(1, 0, 0, 8); step(0, 0, 0, 8);
    check("dis_rejects", rej_seen - br, 2);
    check("dis_dq", (d_seen - bd) + (q_seen - bq), 0);
    step(1, 0, 0, 3); step(1, 0, 1, 5); step(0, 0, 1, 8);
    check("late_enable_d", d_seen - bd, 1);

    // jam: quarter held 100 cycles
    do_reset(); bq = q_seen;
    step(0, 1, 1, 69); check("jam_edge69", int'(bus.jam), 0);
    step(0, 1, 1, 1);  check("jam_edge70", int'(bus.jam), 1);
    step(0, 1, 1, 30);
    step(0, 0, 1, 5);  check("jam_rel5", int'(bus.jam), 1);
    step(0, 0, 1, 1);  check("jam_rel6", int'(bus.jam), 0);
    step(0, 1, 1, 8); step(0, 0, 1, 8);
    check("jam_qpulses", q_seen - bq, 2);
    check("jam_count", int'(bus.coin_count), 2);

    // 260 dimes saturate the counter
    do_reset(); bd = d_seen;
    for (int k = 0; k < 260; k++) begin step(1, 0, 1, 6); step(0, 0, 1, 6); end
    check("sat_count", int'(bus.coin_count), 255);
    check("sat_dpulses", d_seen - bd, 260);

    // reset mid-press: outputs drop at once, still-held dime is a new coin
    step(1, 0, 1, 3);
    #2 reset_n = 0;
    #1;
    check("async_D", int'(bus.D), 0);
    check("async_Q", int'(bus.Q), 0);
    check("async_reject", int'(bus.reject), 0);
    check("async_jam", int'(bus.jam), 0);
    check("async_count", int'(bus.coin_count), 0);
    @(negedge clock);
    reset_n = 1; bd = d_seen;
    step(1, 0, 1, 8); step(0, 0, 1, 8);
    check("post_rst_dpulses", d_seen - bd, 1);
    check("post_rst_count", int'(bus.coin_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a press or a release; legal range 2..255.
REQ-002 Parameter JAM_CYCLES, default 64: accepted-press hold length, counted from the accept edge, that declares a jam; legal range DEBOUNCE_CYCLES+1..65535.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 dime_raw  input  1  unsynchronized mechanical dime sensor; high while a coin is in the slot.
REQ-006 quarter_raw  input  1  unsynchronized mechanical quarter sensor; high while a coin is in the slot.
REQ-007 enable  input  1  synchronous; high = accept coins, low = reject coins.
REQ-008 D  output  1  one-cycle pulse per accepted dime, for the vending FSM D input.
REQ-009 Q  output  1  one-cycle pulse per accepted quarter, for the vending FSM Q input.
REQ-010 reject  output  1  one-cycle pulse per coin refused (enable low, or both sensors active).
REQ-011 jam  output  1  level; high while a jam is declared.
REQ-012 coin_count  output  8  saturating count of D plus Q pulses issued since reset.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic; no raw input drives state directly.
REQ-014 FSM states SHALL be IDLE, PRESS_DB, HELD, RELEASE_DB and JAM.
REQ-015 IDLE: on the first synchronized sample with exactly one sensor high -> PRESS_DB; record the coin type; load the debounce counter.
REQ-016 PRESS_DB: the same sensor high and the other low for DEBOUNCE_CYCLES consecutive samples -> HELD; any glitch -> IDLE with no output.
REQ-017 On entry to HELD, exactly one of D, Q or reject SHALL pulse for one cycle:
  - dime and enable=1: D
  - quarter and enable=1: Q
  - enable=0: reject
  - enable is sampled on the accept cycle only.
REQ-018 Latency: with raw held high from edge 0 and DEBOUNCE_CYCLES=N, the pulse SHALL be high in cycle 2+N (2 synchronizer + N debounce).
REQ-019 Both synchronized sensors high in IDLE or PRESS_DB -> reject pulse, then HELD; no D or Q for that event.
REQ-020 HELD: both sensors low -> RELEASE_DB.
REQ-021 RELEASE_DB: both sensors low for DEBOUNCE_CYCLES consecutive samples -> IDLE; any sensor high -> HELD. A second coin cannot produce a pulse until release is debounced.
REQ-022 In HELD, a hold of JAM_CYCLES cycles counted from the accept edge -> JAM, jam=1; the hold counter SHALL saturate, not wrap.
REQ-023 JAM: jam stays 1, and D, Q and reject stay 0, until both sensors are low for DEBOUNCE_CYCLES samples -> IDLE with jam=0 in the same edge.
REQ-024 At most one of D, Q and reject SHALL be high in any cycle; no output pulse longer than one cycle.
REQ-025 coin_count SHALL increment by 1 on each D or Q pulse and saturate at 255; reject does not count.
REQ-026 Changing enable mid-debounce SHALL not abort the debounce.

Reset
REQ-027 reset_n low SHALL immediately force, asynchronously:
  - FSM to IDLE
  - D=0, Q=0, reject=0, jam=0, coin_count=0
  - synchronizer flops and all counters to 0
REQ-028 Reset asserted mid-debounce or mid-jam SHALL discard the event with no pulse; after release, a sensor still high SHALL be debounced as a new coin.
REQ-029 Reset release SHALL be synchronous to clock; the first state update is the first rising edge with reset_n high.

Verification (DEBOUNCE_CYCLES=4, JAM_CYCLES=64)
REQ-030 quarter_raw high 20 cycles, enable=1 -> Q high exactly in cycle 6 only; coin_count=1; D=reject=0 throughout.
REQ-031 dime_raw three 1-cycle glitches then clean 10-cycle press -> exactly one D pulse; two presses separated by 3 low cycles -> one D pulse; separated by 6 low cycles -> two D pulses.
REQ-032 dime_raw and quarter_raw rising together -> one reject pulse, no D or Q, coin_count unchanged; enable=0 with dime press -> reject pulse only.
REQ-033 quarter_raw held 100 cycles -> Q at cycle 6, jam=1 from cycle 70; jam=0 within 7 cycles of release; a later press works normally.
REQ-034 260 dime presses -> coin_count=255; reset_n pulsed low mid-press -> all outputs 0 at once, no pulse for that press.
